// File: rtl/ssp_ctrl_pkg.sv
// Shared definitions for the SSP host controller: FSM state encoding,
// default requester count and the SSP byte width.
package ssp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    RDCAP = 2'd3
  } state_t;

  localparam int SSP_NREQ_DEFAULT = 4;
  localparam int SSP_BYTE_W       = 8;

endpackage

// File: rtl/ssp_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, wrapping from NREQ-1 back to 0.
module ssp_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx
);

  logic [IDXW:0]   cand_sum [NREQ];
  logic [IDXW-1:0] cand_idx [NREQ];
  logic [NREQ-1:0] cand_hit;

  // Candidate gi is the requester gi positions after the pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, rr_ptr} + (IDXW+1)'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= (IDXW+1)'(NREQ))
                        ? IDXW'(cand_sum[gi] - (IDXW+1)'(NREQ))
                        : IDXW'(cand_sum[gi]);
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  // Scan from the farthest candidate down so the nearest hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/ssp_host_ctrl.sv
// Host-side SSP controller: round-robin TX write arbitration plus RX drain
// into a one-entry valid/ready buffer. Optional counters: SSP_HOST_CTRL_STATS_EN.
module ssp_host_ctrl
  import ssp_ctrl_pkg::*;
#(
  parameter int NREQ = SSP_NREQ_DEFAULT,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic                         PCLK,
  input  logic                         CLEAR_B,
  input  logic [NREQ-1:0]              req,
  input  logic [SSP_BYTE_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]              ack,
  output logic [SSP_BYTE_W-1:0]        rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         PSEL,
  output logic                         PWRITE,
  output logic [SSP_BYTE_W-1:0]        PWDATA,
  input  logic [SSP_BYTE_W-1:0]        PRDATA,
  input  logic                         SSPTXINTR,
  input  logic                         SSPRXINTR
`ifdef SSP_HOST_CTRL_STATS_EN
  ,
  output logic [16*NREQ-1:0]           tx_count,
  output logic [15:0]                  rx_count
`endif
);

  state_t                  state_reg, state_next;
  logic [IDXW-1:0]         rr_ptr_reg, rr_ptr_next;
  logic                    psel_reg, psel_next;
  logic                    pwrite_reg, pwrite_next;
  logic [SSP_BYTE_W-1:0]   pwdata_reg, pwdata_next;
  logic [NREQ-1:0]         ack_reg, ack_next;
  logic [SSP_BYTE_W-1:0]   rx_data_reg;
  logic                    rx_valid_reg;

  logic                    gnt_valid;
  logic [IDXW-1:0]         gnt_idx;
  logic [SSP_BYTE_W-1:0]   req_bytes [NREQ];
  logic                    rx_buf_free;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[SSP_BYTE_W*gi +: SSP_BYTE_W];
  end

  ssp_rr_arb #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // The buffer can take a new byte if empty or being consumed this cycle.
  assign rx_buf_free = !rx_valid_reg || rx_ready;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      psel_reg   <= 1'b0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
      ack_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      psel_reg   <= psel_next;
      pwrite_reg <= pwrite_next;
      pwdata_reg <= pwdata_next;
      ack_reg    <= ack_next;
    end
  end

  // Bus outputs are computed one state ahead so they are registered
  // and coincide with the WR/RD state itself.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    psel_next   = 1'b0;
    pwrite_next = 1'b0;
    pwdata_next = pwdata_reg;
    ack_next    = '0;
    case (state_reg)
      IDLE: begin
        if (SSPRXINTR && rx_buf_free) begin
          state_next = RD;
          psel_next  = 1'b1;
        end else if (gnt_valid && !SSPTXINTR) begin
          state_next        = WR;
          psel_next         = 1'b1;
          pwrite_next       = 1'b1;
          pwdata_next       = req_bytes[gnt_idx];
          ack_next[gnt_idx] = 1'b1;
          rr_ptr_next       = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      WR:      state_next = IDLE;
      RD:      state_next = RDCAP;
      RDCAP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A capture in the same cycle as a handshake reloads and keeps valid high.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else if (state_reg == RDCAP) begin
      rx_data_reg  <= PRDATA;
      rx_valid_reg <= 1'b1;
    end else if (rx_valid_reg && rx_ready) begin
      rx_valid_reg <= 1'b0;
    end
  end

  assign PSEL     = psel_reg;
  assign PWRITE   = pwrite_reg;
  assign PWDATA   = pwdata_reg;
  assign ack      = ack_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

`ifdef SSP_HOST_CTRL_STATS_EN
  logic [15:0] tx_cnt_reg [NREQ];
  logic [15:0] rx_cnt_reg;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_tx_cnt
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
        tx_cnt_reg[gi] <= '0;
      end else if (ack_reg[gi]) begin
        tx_cnt_reg[gi] <= tx_cnt_reg[gi] + 16'd1;
      end
    end
    assign tx_count[16*gi +: 16] = tx_cnt_reg[gi];
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      rx_cnt_reg <= '0;
    end else if (state_reg == RDCAP) begin
      rx_cnt_reg <= rx_cnt_reg + 16'd1;
    end
  end
  assign rx_count = rx_cnt_reg;
`endif

endmodule

// File: tb/tb_ssp_host_ctrl.sv
// Directed bench for ssp_host_ctrl with write/read scoreboards and a tiny SSP FIFO model.
module tb_ssp_host_ctrl;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } wr_exp_t;

  logic        PCLK;
  logic        CLEAR_B;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        PSEL;
  logic        PWRITE;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA;
  logic        SSPTXINTR;
  logic        SSPRXINTR;
`ifdef SSP_HOST_CTRL_STATS_EN
  logic [63:0] tx_count;
  logic [15:0] rx_count;
`endif

  ssp_host_ctrl dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .SSPTXINTR (SSPTXINTR),
    .SSPRXINTR (SSPRXINTR)
`ifdef SSP_HOST_CTRL_STATS_EN
    ,
    .tx_count  (tx_count),
    .rx_count  (rx_count)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  bit tx_full  = 0;
  bit hold_req = 0;

  wr_exp_t    wq[$];
  logic [7:0] rxq[$];
  logic [7:0] ssp_rx[$];
  int         wcyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic ssp_push(input logic [7:0] b);
    ssp_rx.push_back(b);
    SSPRXINTR = 1'b1;
  endtask

  // One clock: score the handshake due at this edge, then sample after it.
  task automatic tick();
    wr_exp_t    e;
    logic [3:0] onehot;
    logic [7:0] rexp;
    if (rx_valid && rx_ready) begin
      n_assert++;
      assert (rxq.size() != 0)
        else begin
          n_fail++;
          $error("FAIL rx_unexpected observed=%0h expected=none", rx_data);
        end
      if (rxq.size() != 0) begin
        rexp = rxq.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, rexp});
      end
    end
    @(posedge PCLK);
    #1;
    cyc++;
    if (PSEL && PWRITE) begin
      wr_cnt++;
      n_assert++;
      assert (wq.size() != 0)
        else begin
          n_fail++;
          $error("FAIL wr_unexpected observed=%0h expected=none", PWDATA);
        end
      if (wq.size() != 0) begin
        e      = wq.pop_front();
        onehot = 4'b0001 << e.idx;
        check("wr_data", {24'd0, PWDATA}, {24'd0, e.data});
        check("wr_ack", {28'd0, ack}, {28'd0, onehot});
      end
      $display("cyc %0d: write data=%02h ack=%b", cyc, PWDATA, ack);
    end else begin
      check("ack_quiet", {28'd0, ack}, 32'd0);
    end
    if (PSEL && !PWRITE) begin
      rd_cnt++;
      if (ssp_rx.size() != 0) begin
        PRDATA = ssp_rx.pop_front();
        rxq.push_back(PRDATA);
      end
      $display("cyc %0d: read access prdata=%02h", cyc, PRDATA);
    end
    SSPRXINTR = (ssp_rx.size() != 0);
    SSPTXINTR = tx_full;
    if (!hold_req) begin
      for (int i = 0; i < 4; i++) if (ack[i]) req[i] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_wr, base_rd, rd_after_rst, t, rcyc, wc6;

    CLEAR_B = 1'b0; req = '0; req_data = '0; rx_ready = 1'b0;
    PRDATA = '0; SSPTXINTR = 1'b0; SSPRXINTR = 1'b0;
    tick(); tick();
    check("rst_psel", {31'd0, PSEL}, 32'd0);
    check("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    check("rst_pwdata", {24'd0, PWDATA}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    CLEAR_B = 1'b1;
    tick();

    // Reset in the middle of a write.
    req_data[7:0] = 8'h3C;
    wq.push_back('{idx: 2'd0, data: 8'h3C});
    req = 4'b0001;
    for (t = 0; t < 10 && !PSEL; t++) tick();
    check("t1_psel_seen", {31'd0, PSEL}, 32'd1);
    CLEAR_B = 1'b0;
    #1;
    check("t1_psel_abort", {31'd0, PSEL}, 32'd0);
    check("t1_ack_abort", {28'd0, ack}, 32'd0);
    check("t1_pwdata_abort", {24'd0, PWDATA}, 32'd0);
    check("t1_rx_valid_abort", {31'd0, rx_valid}, 32'd0);
    tick(); tick();
    CLEAR_B = 1'b1;
    rd_after_rst = rd_cnt;
    tick();

    // All four request; A0 first shows rr_ptr went back to 0.
    req_data = 32'hA3A2A1A0;
    for (int i = 0; i < 4; i++) wq.push_back('{idx: 2'(i), data: 8'hA0 + 8'(i)});
    wcyc.delete();
    req = 4'b1111;
    for (t = 0; t < 20 && wq.size() != 0; t++) begin
      tick();
      if (PSEL && PWRITE) wcyc.push_back(cyc);
    end
    check("t2_write_count", wcyc.size(), 32'd4);
    if (wcyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check("t2_write_spacing", wcyc[i] - wcyc[i-1], 32'd2);
    end
    tick();

    // TX FIFO full holds off the write.
    tx_full = 1; SSPTXINTR = 1'b1;
    req_data[7:0] = 8'h11;
    wq.push_back('{idx: 2'd0, data: 8'h11});
    req = 4'b0001;
    base_wr = wr_cnt;
    repeat (10) tick();
    check("t3_no_write", wr_cnt - base_wr, 32'd0);
    check("t3_still_pending", wq.size(), 32'd1);
    tx_full = 0; SSPTXINTR = 1'b0;
    for (t = 0; t < 6 && wr_cnt == base_wr; t++) tick();
    check("t3_latency_ok", {31'd0, (t >= 1 && t <= 2)}, 32'd1);
    repeat (3) tick();
    check("t3_single_write", wr_cnt - base_wr, 32'd1);

    // Single read: RD, RDCAP, then valid.
    rx_ready = 1'b1;
    ssp_push(8'h5C);
    base_rd = rd_cnt;
    for (t = 0; t < 10 && rd_cnt == base_rd; t++) tick();
    check("t4_read_seen", rd_cnt - base_rd, 32'd1);
    check("t4_rd_pwrite", {31'd0, PWRITE}, 32'd0);
    tick();
    check("t4_rdcap_psel", {31'd0, PSEL}, 32'd0);
    check("t4_rdcap_valid", {31'd0, rx_valid}, 32'd0);
    tick();
    check("t4_valid", {31'd0, rx_valid}, 32'd1);
    check("t4_data", {24'd0, rx_data}, 32'h5C);
    tick();
    check("t4_consumed", {31'd0, rx_valid}, 32'd0);

    // Full rx buffer blocks reads but not writes.
    rx_ready = 1'b0;
    ssp_push(8'h71);
    ssp_push(8'h72);
    for (t = 0; t < 10 && !rx_valid; t++) tick();
    check("t5_buf_full", {31'd0, rx_valid}, 32'd1);
    base_rd = rd_cnt; base_wr = wr_cnt;
    req_data[15:8] = 8'h42;
    wq.push_back('{idx: 2'd1, data: 8'h42});
    req = 4'b0010;
    repeat (8) tick();
    check("t5_no_read", rd_cnt - base_rd, 32'd0);
    check("t5_write_done", wr_cnt - base_wr, 32'd1);
    check("t5_data_held", {24'd0, rx_data}, 32'h71);
    rx_ready = 1'b1;
    for (t = 0; t < 20 && (rxq.size() != 0 || ssp_rx.size() != 0 || rx_valid); t++) tick();
    check("t5_read_resumed", rd_cnt - base_rd, 32'd1);
    check("t5_drained", rxq.size(), 32'd0);

    // Read and write requested together: read first.
    req_data[31:24] = 8'h99;
    wq.push_back('{idx: 2'd3, data: 8'h99});
    ssp_push(8'h66);
    req = 4'b1000;
    for (t = 0; t < 10 && !PSEL; t++) tick();
    check("t6_first_is_read", {31'd0, PWRITE}, 32'd0);
    rcyc = cyc;
    wc6 = 0;
    for (t = 0; t < 10 && wq.size() != 0; t++) begin
      tick();
      if (PSEL && PWRITE) wc6 = cyc;
    end
    check("t6_write_after_read", wc6 - rcyc, 32'd3);
    repeat (3) tick();
    check("t6_rx_drained", rxq.size(), 32'd0);

    // Held requests alternate fairly.
    hold_req = 1;
    req_data[7:0] = 8'hC0; req_data[23:16] = 8'hC2;
    wq.push_back('{idx: 2'd0, data: 8'hC0});
    wq.push_back('{idx: 2'd2, data: 8'hC2});
    wq.push_back('{idx: 2'd0, data: 8'hC0});
    wq.push_back('{idx: 2'd2, data: 8'hC2});
    req = 4'b0101;
    for (t = 0; t < 20 && wq.size() != 0; t++) tick();
    req = 4'b0000;
    hold_req = 0;
    check("t7_fair_done", wq.size(), 32'd0);
    tick(); tick();

    // Withdrawn request is never written.
    tx_full = 1; SSPTXINTR = 1'b1;
    base_wr = wr_cnt;
    req = 4'b0100;
    repeat (3) tick();
    req = 4'b0000;
    tick();
    tx_full = 0; SSPTXINTR = 1'b0;
    repeat (5) tick();
    check("t8_withdrawn", wr_cnt - base_wr, 32'd0);

`ifdef SSP_HOST_CTRL_STATS_EN
    check("stats_rx_count", {16'd0, rx_count}, rd_cnt - rd_after_rst);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
